fifo_wr_arbiter: RTL

//  Shares one fifo write port between NUM_REQ producers using round-robin or fixed-priority arbitration.

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding, arbitration mode constants and pointer sizing for fifo_wr_arbiter
package fifo_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, BLOCKED} arb_state_e;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational winner search, rotating from start in round-robin mode or from index 0 in fixed mode
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   start,
    input  logic               mode,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx
);

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (mode == ARB_FIXED) ? k : (int'(start) + k) % NUM_REQ;
            if (valid[j]) idx = PTR_W'(j);
        end
        gnt[idx] = |valid;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one fifo write port among NUM_REQ producers, never issuing a write the fifo
// could refuse, and flags any write that goes unacknowledged.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arb_mode,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_gnt,
    output logic                          wr_en,
    output logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          full,
    input  logic                          almostfull,
    input  logic                          wr_ack,
    input  logic                          overflow,
    output logic                          blocked,
    output logic                          err,
    output logic [7:0]                    drop_cnt
);

    localparam int PTR_W = ptr_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || FIFO_DEPTH < 2) begin : g_bad_params
        $error("fifo_wr_arbiter: unsupported NUM_REQ or FIFO_DEPTH");
    end

    arb_state_e         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_gnt;
    logic               wr_en_d;
    logic               any_valid;
    logic               space_ok;
    logic               xfer;

    // A registered wr_en is a word the fifo has not counted yet, so almostfull already means no room.
    assign any_valid = |req_valid;
    assign space_ok  = !full && !(wr_en && almostfull);
    assign req_gnt   = (rst_n && space_ok) ? win_gnt : '0;
    assign xfer      = |(req_valid & req_gnt);
    assign blocked   = state == BLOCKED;

    rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .valid (req_valid),
        .start (rr_ptr),
        .mode  (arb_mode),
        .gnt   (win_gnt),
        .idx   (win_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            wr_en    <= 1'b0;
            data_in  <= '0;
            wr_en_d  <= 1'b0;
            err      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state   <= !any_valid ? IDLE : space_ok ? ISSUE : BLOCKED;
            wr_en   <= xfer;
            wr_en_d <= wr_en;
            if (xfer)
                data_in <= req_data[int'(win_idx)*FIFO_WIDTH +: FIFO_WIDTH];
            if (xfer && arb_mode == ARB_RR)
                rr_ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            if (wr_en_d && !wr_ack) begin
                drop_cnt <= drop_cnt + {7'd0, drop_cnt != 8'hff};
                err      <= 1'b1;
            end
            if (overflow)
                err <= 1'b1;
        end
    end

`ifdef SIM
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_gnt));
    a_no_wr_full: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));
    a_wr_ack:     assert property (@(posedge clk) disable iff (!rst_n) wr_en |=> wr_ack);
`endif

endmodule
